// File: rtl/bit_pack_pkg.sv
// Shared constants and helpers for the bit packer.
// Widths: 32-bit words, fields of up to 15 bits, 47-bit accumulator.
// Optional build macro BIT_PACK_MSB_FIRST_EN selects MSB-first packing.
package bit_pack_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 15;
  localparam int ACC_W  = WORD_W + DATA_W;
  localparam int CNT_W  = 6;

  // Low-order mask covering the first len bits of a field.
  function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [DATA_W:0] m;
    m = ((DATA_W+1)'(1) << len) - (DATA_W+1)'(1);
    return m[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/bit_pack_align.sv
// Combinational field alignment: masks a field, shifts it into the accumulator, forms output words.
// Latency: zero (pure combinational).
// Backpressure: none; BIT_PACK_MSB_FIRST_EN reverses bit order within fields and within words.
module bit_pack_align
  import bit_pack_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0]  nxt,
  output logic [CNT_W-1:0]  ncnt,
  output logic [WORD_W-1:0] full_word,
  output logic [WORD_W-1:0] part_word
);

  logic [DATA_W-1:0] masked;
  logic [DATA_W-1:0] field;
  logic [WORD_W:0]   pad_mask;
  logic [WORD_W-1:0] s_full;
  logic [WORD_W-1:0] s_part;

  // The accumulator always holds the bit stream oldest-first at bit 0;
  // MSB-first mode only changes how fields enter and how words leave.
  always_comb begin
    masked = data & len_mask(len);
    field  = '0;
`ifdef BIT_PACK_MSB_FIRST_EN
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(len)) field[i] = masked[int'(len) - 1 - i];
    end
`else
    field = masked;
`endif
    nxt      = acc | (ACC_W'(field) << cnt);
    ncnt     = cnt + CNT_W'(len);
    pad_mask = ((WORD_W+1)'(1) << ncnt) - (WORD_W+1)'(1);
    s_full   = nxt[WORD_W-1:0];
    s_part   = s_full & pad_mask[WORD_W-1:0];
    full_word = s_full;
    part_word = s_part;
`ifdef BIT_PACK_MSB_FIRST_EN
    for (int j = 0; j < WORD_W; j++) begin
      full_word[WORD_W-1-j] = s_full[j];
      part_word[WORD_W-1-j] = s_part[j];
    end
`endif
  end

endmodule

// File: rtl/bit_pack.sv
// Repacks 0..15-bit fields into dense 32-bit words; flush emits a zero-padded partial word.
// Latency: 1 cycle from input edge to pushout strobe; one-deep pending flush when a full word wins.
// Backpressure: none, push-only; cannot overflow. Macro BIT_PACK_MSB_FIRST_EN selects MSB-first order.
module bit_pack
  import bit_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pushin,
  input  logic [LEN_W-1:0]  lenin,
  input  logic [DATA_W-1:0] datain,
  input  logic              flushin,
  output logic              pushout,
  output logic [WORD_W-1:0] dataout,
  output logic [5:0]        validbits
);

  logic [ACC_W-1:0]  acc, acc_n, nxt;
  logic [CNT_W-1:0]  cnt, cnt_n, ncnt;
  logic              flush_pend, flush_pend_n;
  logic [LEN_W-1:0]  eff_len;
  logic [WORD_W-1:0] full_word, part_word;
  logic              emit;
  logic [WORD_W-1:0] word_n;
  logic [5:0]        vb_n;
  logic              flush_req;

  assign eff_len = pushin ? lenin : '0;

  bit_pack_align u_align (
    .acc       (acc),
    .cnt       (cnt),
    .len       (eff_len),
    .data      (datain),
    .nxt       (nxt),
    .ncnt      (ncnt),
    .full_word (full_word),
    .part_word (part_word)
  );

  // Decide between full word, partial flush word or plain accumulation.
  always_comb begin
    flush_req    = flushin | flush_pend;
    acc_n        = nxt;
    cnt_n        = ncnt;
    flush_pend_n = 1'b0;
    emit         = 1'b0;
    word_n       = full_word;
    vb_n         = 6'd32;
    if (ncnt >= CNT_W'(WORD_W)) begin
      // Full word wins; any flush request waits one cycle.
      emit         = 1'b1;
      acc_n        = nxt >> WORD_W;
      cnt_n        = ncnt - CNT_W'(WORD_W);
      flush_pend_n = flush_req;
    end else if (flush_req) begin
      if (ncnt != '0) begin
        emit   = 1'b1;
        word_n = part_word;
        vb_n   = ncnt;
        acc_n  = '0;
        cnt_n  = '0;
      end
    end
  end

  // Accumulator state and registered output strobe/word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      pushout    <= 1'b0;
      dataout    <= '0;
      validbits  <= '0;
    end else begin
      acc        <= acc_n;
      cnt        <= cnt_n;
      flush_pend <= flush_pend_n;
      pushout    <= emit;
      if (emit) begin
        dataout   <= word_n;
        validbits <= vb_n;
      end
    end
  end

endmodule

// File: tb/tb_bit_pack.sv
// Scoreboard bench for bit_pack: expected words queued at stimulus time, popped by a monitor.
// Each expectation carries the cycle on which the strobe must appear.
// Build with BIT_PACK_MSB_FIRST_EN to run the MSB-first vector instead of the LSB-first set.
module tb_bit_pack;

  logic        clk;
  logic        rst;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flushin;
  logic        pushout;
  logic [31:0] dataout;
  logic [5:0]  validbits;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  vb;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   checks;
  int   errors;

  bit_pack dut (
    .clk       (clk),
    .rst       (rst),
    .pushin    (pushin),
    .lenin     (lenin),
    .datain    (datain),
    .flushin   (flushin),
    .pushout   (pushout),
    .dataout   (dataout),
    .validbits (validbits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (rst && pushout) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word cyc=%0d dataout=%h validbits=%0d required=no strobe", cyc, dataout, validbits);
      end else begin
        mon_e = sb.pop_front();
        if (dataout !== mon_e.d || validbits !== mon_e.vb || cyc != mon_e.cyc)
          begin
            errors++;
            $display("FAIL word cyc=%0d dataout=%h validbits=%0d required cyc=%0d dataout=%h validbits=%0d",
                     cyc, dataout, validbits, mon_e.cyc, mon_e.d, mon_e.vb);
          end
      end
    end
  end

  task automatic expect_word(input logic [31:0] d, input logic [5:0] vb, input int dly);
    exp_t e;
    e.d   = d;
    e.vb  = vb;
    e.cyc = cyc + dly;
    sb.push_back(e);
  endtask

  // Present one cycle of inputs, then return #1 after the sampling edge.
  task automatic cycle(input logic p, input logic [3:0] l, input logic [14:0] d, input logic f);
    pushin  = p;
    lenin   = l;
    datain  = d;
    flushin = f;
    @(posedge clk);
    #1;
    pushin  = 1'b0;
    lenin   = '0;
    datain  = '0;
    flushin = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b0; pushin = 1'b0; lenin = '0; datain = '0; flushin = 1'b0;
    #12;
    check_val("reset_pushout", {31'b0, pushout}, 32'h0);
    check_val("reset_dataout", dataout, 32'h0);
    check_val("reset_validbits", {26'b0, validbits}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef BIT_PACK_MSB_FIRST_EN
    // First bit received lands at dataout[31]; padding in the low bits.
    cycle(1'b1, 4'd4, 15'h0001, 1'b0);
    expect_word(32'h1000_0000, 6'd4, 1);
    cycle(1'b0, 4'd0, 15'h0, 1'b1);
    // Two fields: 3'b101 then 2'b01 -> stream 1,0,1,0,1.
    cycle(1'b1, 4'd3, 15'h0005, 1'b0);
    expect_word(32'hA800_0000, 6'd5, 1);
    cycle(1'b1, 4'd2, 15'h0001, 1'b1);
`else
    // Eight nibbles of A -> one full word after the eighth push.
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'd4, 15'h000A, 1'b0);
    expect_word(32'hAAAA_AAAA, 6'd32, 1);
    cycle(1'b1, 4'd4, 15'h000A, 1'b0);

    // 45 ones: full word then 13-bit residue on flush.
    cycle(1'b1, 4'd15, 15'h7FFF, 1'b0);
    cycle(1'b1, 4'd15, 15'h7FFF, 1'b0);
    expect_word(32'hFFFF_FFFF, 6'd32, 1);
    cycle(1'b1, 4'd15, 15'h7FFF, 1'b0);
    expect_word(32'h0000_1FFF, 6'd13, 1);
    cycle(1'b0, 4'd0, 15'h0, 1'b1);

    // Bits above lenin are ignored.
    cycle(1'b1, 4'd3, 15'h7FF8, 1'b0);
    expect_word(32'h0000_0000, 6'd3, 1);
    cycle(1'b0, 4'd0, 15'h0, 1'b1);

    // Push+flush crossing 32: full word first, partial word next cycle.
    cycle(1'b1, 4'd15, 15'h0, 1'b0);
    cycle(1'b1, 4'd15, 15'h0, 1'b0);
    expect_word(32'hC000_0000, 6'd32, 1);
    expect_word(32'h0000_0007, 6'd3, 2);
    cycle(1'b1, 4'd5, 15'h001F, 1'b1);
    cycle(1'b0, 4'd0, 15'h0, 1'b0);

    // Pending flush completing on a push cycle includes that field: 7 | 9<<3 = 0x4F.
    cycle(1'b1, 4'd15, 15'h0, 1'b0);
    cycle(1'b1, 4'd15, 15'h0, 1'b0);
    expect_word(32'hC000_0000, 6'd32, 1);
    expect_word(32'h0000_004F, 6'd7, 2);
    cycle(1'b1, 4'd5, 15'h001F, 1'b1);
    cycle(1'b1, 4'd4, 15'h0009, 1'b0);

    // Flush with nothing accumulated and a zero-length push: no strobe.
    cycle(1'b1, 4'd0, 15'h7FFF, 1'b1);
    cycle(1'b0, 4'd0, 15'h0, 1'b0);

    // Async reset mid-accumulation (cnt=20) clears outputs at once and discards bits.
    cycle(1'b1, 4'd15, 15'h1234, 1'b0);
    cycle(1'b1, 4'd5, 15'h001F, 1'b0);
    rst = 1'b0;
    #2;
    check_val("async_rst_pushout", {31'b0, pushout}, 32'h0);
    check_val("async_rst_dataout", dataout, 32'h0);
    check_val("async_rst_validbits", {26'b0, validbits}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1'b0, 4'd0, 15'h0, 1'b1);
    cycle(1'b0, 4'd0, 15'h0, 1'b0);
    expect_word(32'h0000_0005, 6'd4, 1);
    cycle(1'b1, 4'd4, 15'h0005, 1'b1);
`endif

    repeat (4) cycle(1'b0, 4'd0, 15'h0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_words outstanding=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
